// File: rtl/ssd_pkg.sv
// Shared types and constants for the multiplexed seven-segment display.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package ssd_pkg;

    // Binary-to-digit conversion sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // All cathodes off (active-low segments)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex nibble to active-low {a,b,c,d,e,f,g} cathode pattern
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// Binary to display-digit converter: shift-add-3 decimal or raw hex nibbles.
// Latency: hex 1 cycle, decimal VAL_W+1 cycles from start to digit update.
// Backpressure: start is accepted only in IDLE or COMMIT (busy_o/done_o tell the caller).
module ssd_bin2bcd
    import ssd_pkg::*;
#(
    parameter int VAL_W      = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic                    start_i,
    input  logic [VAL_W-1:0]        value_i,
    input  logic                    hex_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [NUM_DIGITS*4-1:0] digits_o,
    output logic                    ovf_o
);

    localparam int DW    = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam logic [63:0] DEC_MAX = 64'(10 ** NUM_DIGITS - 1);

    conv_state_e      state_q, state_d;
    logic [VAL_W-1:0] val_q, val_d, sr_q, sr_d;
    logic             hex_q, hex_d;
    logic [DW-1:0]    bcd_q, bcd_d, bcd_adj, dig_q, dig_d, hex_dig;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, too_big;

    // Hex digits are the captured value's nibbles, zero-extended or truncated to the display
    if (VAL_W >= DW) begin : g_hex_trunc
        assign hex_dig = val_q[DW-1:0];
    end else begin : g_hex_ext
        assign hex_dig = {{(DW - VAL_W){1'b0}}, val_q};
    end

    // Overflow is judged on the whole captured value, so the BCD register needs only NUM_DIGITS digits
    assign too_big = ({{(64 - VAL_W){1'b0}}, val_q} > DEC_MAX);

    // Add-3 correction of every BCD digit that is 5 or more before the next shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (bcd_q[k*4 +: 4] >= 4'd5) begin
                bcd_adj[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
            end
        end
    end

    // Sequencer: shift one bit per cycle, publish digits only in COMMIT, chain a new start from COMMIT
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        sr_d    = sr_q;
        hex_d   = hex_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        case (state_q)
            SHIFT: begin
                bcd_d = {bcd_adj[DW-2:0], sr_q[VAL_W-1]};
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VAL_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (hex_q) begin
                    dig_d = hex_dig;
                    ovf_d = 1'b0;
                end else if (too_big) begin
                    dig_d = {NUM_DIGITS{4'd9}};
                    ovf_d = 1'b1;
                end else begin
                    dig_d = bcd_q;
                    ovf_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (start_i && (state_q != SHIFT)) begin
            val_d   = value_i;
            sr_d    = value_i;
            hex_d   = hex_i;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = hex_i ? COMMIT : SHIFT;
        end
    end

    // Conversion state and published digits
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            val_q   <= '0;
            sr_q    <= '0;
            hex_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            sr_q    <= sr_d;
            hex_q   <= hex_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == COMMIT);
    assign digits_o = dig_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/ssd_scan_display.sv
// Multiplexed seven-segment driver: load/convert a value, scan digits with blanking.
// Latency: display follows a commit one clock later; an/seg/dp are registered together.
// Backpressure: a load while busy parks in a one-deep pending slot (newest wins), no stall.
module ssd_scan_display
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_BITS = 18,
    parameter int VAL_W         = 14
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic [VAL_W-1:0]      value,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  blank_lz,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic                  busy,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    pend_vld_q, pend_vld_d, pend_hex_q, pend_hex_d;
    logic [VAL_W-1:0]        pend_val_q, pend_val_d;
    logic                    conv_start, conv_hex, conv_done;
    logic [VAL_W-1:0]        conv_val;
    logic [NUM_DIGITS*4-1:0] digits;
    logic [SCAN_DIV_BITS-1:0] pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   blank_vec, an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d, upper_nz, cur_blank, cur_dp;
    logic [3:0]              cur_dig;

    // Start from idle on a load, or chain straight out of COMMIT (a same-cycle load beats the parked one)
    always_comb begin
        conv_start = (load && !busy) || (conv_done && (pend_vld_q || load));
        conv_val   = load ? value : pend_val_q;
        conv_hex   = load ? hex_mode : pend_hex_q;
        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        pend_hex_d = pend_hex_q;
        if (conv_done && (pend_vld_q || load)) begin
            pend_vld_d = 1'b0;
        end else if (load && busy) begin
            pend_vld_d = 1'b1;
            pend_val_d = value;
            pend_hex_d = hex_mode;
        end
    end

    ssd_bin2bcd #(
        .VAL_W      (VAL_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .board_clk (board_clk),
        .Reset     (Reset),
        .start_i   (conv_start),
        .value_i   (conv_val),
        .hex_i     (conv_hex),
        .busy_o    (busy),
        .done_o    (conv_done),
        .digits_o  (digits),
        .ovf_o     (ovf)
    );

    // Scan timing: free-running prescaler, digit index advances on its terminal count
    always_comb begin
        pre_d = pre_q + SCAN_DIV_BITS'(1);
        idx_d = idx_q;
        if (&pre_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Leading-zero mask: a digit above 0 blanks when it and everything above it are zero
    always_comb begin
        upper_nz  = 1'b0;
        blank_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_nz = upper_nz | (digits[i*4 +: 4] != 4'd0);
            if (i != 0) begin
                blank_vec[i] = blank_lz & ~upper_nz;
            end
        end
    end

    // Pick the digit, blank flag and decimal point for the current scan slot
    always_comb begin
        cur_dig   = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig   = digits[i*4 +: 4];
                cur_blank = blank_vec[i];
                cur_dp    = dp_mask[i];
            end
        end
    end

    // Next anode/cathode pattern; a blanked slot turns everything off
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!cur_blank) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = seg_decode(cur_dig);
            dp_d  = ~cur_dp;
        end
    end

    // Pending slot, scan counters and the display output registers
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
            pend_hex_q <= 1'b0;
            pre_q      <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
            pend_hex_q <= pend_hex_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_ssd_scan_display.sv
// Self-checking bench: transaction-level model predicts every cycle's outputs into a queue.
// Latency: one expectation per clock edge, compared on the following falling edge.
// Backpressure: none; stimulus is cycle-driven and never waits on the DUT.
module tb_ssd_scan_display;

    localparam int N    = 4;
    localparam int VW   = 14;
    localparam int SDB  = 4;
    localparam int SLOT = 1 << SDB;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic         busy;
        logic         ovf;
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
    } exp_t;

    typedef struct packed {
        logic       busy;
        logic       ovf;
        logic [2:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp3_t;

    localparam exp_t  RST_E  = '{busy: 1'b0, ovf: 1'b0, an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
    localparam exp3_t RST_E3 = '{busy: 1'b0, ovf: 1'b0, an: 3'b111, seg: 7'b1111111, dp: 1'b1};

    logic          board_clk = 1'b0;
    logic          Reset;
    logic [VW-1:0] value;
    logic          load, hex_mode, blank_lz;
    logic [N-1:0]  dp_mask;
    logic          busy, ovf, dp;
    logic [N-1:0]  an;
    logic [6:0]    seg;
    logic          busy3, ovf3, dp3;
    logic [2:0]    an3;
    logic [6:0]    seg3;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t  expq[$];
    exp3_t exp3q[$];

    always #5 board_clk = ~board_clk;

    ssd_scan_display #(.NUM_DIGITS(N), .SCAN_DIV_BITS(SDB), .VAL_W(VW)) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .value     (value),
        .load      (load),
        .hex_mode  (hex_mode),
        .blank_lz  (blank_lz),
        .dp_mask   (dp_mask),
        .busy      (busy),
        .ovf       (ovf),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    ssd_scan_display #(.NUM_DIGITS(3), .SCAN_DIV_BITS(SDB), .VAL_W(VW)) dut3 (
        .board_clk (board_clk),
        .Reset     (Reset),
        .value     (value),
        .load      (1'b0),
        .hex_mode  (1'b0),
        .blank_lz  (1'b0),
        .dp_mask   (3'b000),
        .busy      (busy3),
        .ovf       (ovf3),
        .an        (an3),
        .seg       (seg3),
        .dp        (dp3)
    );

    // ---------------- reference model (transaction level) ----------------
    int t;                        // clock edges since time zero
    int pre_m, idx_m, idx3_m;     // cycle within slot, displayed digit index
    int dv[N];                    // digit values currently shown
    bit ovf_m;
    bit active;                   // a job is being converted
    int job_end;                  // edge at which the active job commits
    int job_dv[N];
    bit job_ovf;
    bit pend_vld, pend_hex;
    int pend_val;

    task automatic start_job(input int v, input bit h);
        int p;
        active   = 1'b1;
        pend_vld = 1'b0;
        job_end  = t + (h ? 1 : VW + 1);
        job_ovf  = 1'b0;
        if (h) begin
            for (int i = 0; i < N; i++) job_dv[i] = (v >> (4 * i)) & 15;
        end else if (v > 10 ** N - 1) begin
            for (int i = 0; i < N; i++) job_dv[i] = 9;
            job_ovf = 1'b1;
        end else begin
            p = 1;
            for (int i = 0; i < N; i++) begin
                job_dv[i] = (v / p) % 10;
                p = p * 10;
            end
        end
    endtask

    function automatic bit digit_blanked(input int i);
        if (i == 0 || !blank_lz) return 1'b0;
        for (int j = i; j < N; j++) if (dv[j] != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock edge of the model: predict the outputs seen after this edge
    task automatic model_edge();
        exp_t        e;
        exp3_t       e3;
        bit          blk;
        logic [N-1:0] one_n;
        logic [2:0]  one_3;
        one_n = 1;
        one_3 = 1;
        if (Reset) begin
            pre_m = 0; idx_m = 0; idx3_m = 0;
            for (int i = 0; i < N; i++) dv[i] = 0;
            ovf_m = 1'b0; active = 1'b0; pend_vld = 1'b0;
            e  = RST_E;
            e3 = RST_E3;
        end else begin
            blk   = digit_blanked(idx_m);
            e.an  = blk ? {N{1'b1}} : ~(one_n << idx_m);
            e.seg = blk ? 7'b1111111 : SEG_TAB[dv[idx_m]];
            e.dp  = blk ? 1'b1 : ~dp_mask[idx_m];
            e3.an   = ~(one_3 << idx3_m);
            e3.seg  = SEG_TAB[0];
            e3.dp   = 1'b1;
            e3.busy = 1'b0;
            e3.ovf  = 1'b0;
            if (pre_m == SLOT - 1) begin
                idx_m  = (idx_m + 1) % N;
                idx3_m = (idx3_m + 1) % 3;
            end
            pre_m = (pre_m + 1) % SLOT;
            if (active && t == job_end) begin
                for (int i = 0; i < N; i++) dv[i] = job_dv[i];
                ovf_m  = job_ovf;
                active = 1'b0;
            end
            if (load) begin
                if (active) begin
                    pend_vld = 1'b1;
                    pend_val = int'(value);
                    pend_hex = hex_mode;
                end else begin
                    start_job(int'(value), hex_mode);
                end
            end else if (!active && pend_vld) begin
                start_job(pend_val, pend_hex);
            end
            e.busy = active;
            e.ovf  = ovf_m;
        end
        t = t + 1;
        expq.push_back(e);
        exp3q.push_back(e3);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t  e;
        exp3_t e3;
        forever begin
            @(negedge board_clk);
            if (expq.size() > 0) begin
                e  = expq.pop_front();
                e3 = exp3q.pop_front();
                if (Reset) begin
                    e  = RST_E;
                    e3 = RST_E3;
                end
                n_tests++;
                if ({busy, ovf, an, seg, dp} !== e) begin
                    n_fail++;
                    $display("FAIL disp4 @%0t: got busy=%b ovf=%b an=%b seg=%b dp=%b, want busy=%b ovf=%b an=%b seg=%b dp=%b",
                             $time, busy, ovf, an, seg, dp, e.busy, e.ovf, e.an, e.seg, e.dp);
                end
                n_tests++;
                if ({busy3, ovf3, an3, seg3, dp3} !== e3) begin
                    n_fail++;
                    $display("FAIL scan3 @%0t: got busy=%b ovf=%b an=%b seg=%b dp=%b, want busy=%b ovf=%b an=%b seg=%b dp=%b",
                             $time, busy3, ovf3, an3, seg3, dp3, e3.busy, e3.ovf, e3.an, e3.seg, e3.dp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge board_clk);
            model_edge();
            @(negedge board_clk);
        end
    endtask

    task automatic do_load(input int v, input bit h);
        value    = VW'(v);
        hex_mode = h;
        load     = 1'b1;
        tick(1);
        load     = 1'b0;
    endtask

    // Reset asserted between edges: outputs must clear before the next falling edge
    task automatic async_reset(input int hold);
        @(posedge board_clk);
        model_edge();
        #2 Reset = 1'b1;
        @(negedge board_clk);
        tick(hold);
        Reset = 1'b0;
    endtask

    initial begin
        t = 0; pre_m = 0; idx_m = 0; idx3_m = 0; ovf_m = 0;
        active = 0; pend_vld = 0; job_end = 0; job_ovf = 0; pend_val = 0; pend_hex = 0;
        for (int i = 0; i < N; i++) begin dv[i] = 0; job_dv[i] = 0; end
        Reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0; blank_lz = 1'b0; dp_mask = '0;
        tick(3);
        Reset = 1'b0;
        tick(40);
        async_reset(2);
        tick(10);

        do_load(1234, 1'b0);
        tick(90);

        do_load(12000, 1'b0);
        tick(85);
        do_load(5, 1'b0);
        tick(30);

        blank_lz = 1'b1;
        do_load(7, 1'b0);
        tick(80);
        do_load(0, 1'b0);
        tick(80);
        dp_mask = 4'b1000;
        tick(70);
        dp_mask = 4'b0011;
        do_load(7, 1'b0);
        tick(70);

        blank_lz = 1'b0;
        dp_mask  = 4'b0000;
        do_load(14'h2BEF, 1'b1);
        tick(70);

        do_load(1234, 1'b0);
        tick(2);
        do_load(56, 1'b0);
        tick(1);
        do_load(78, 1'b0);
        tick(100);

        do_load(300, 1'b0);
        tick(14);
        do_load(4321, 1'b0);
        tick(40);

        do_load(999, 1'b0);
        tick(5);
        async_reset(2);
        tick(70);

        for (int r = 0; r < 40; r++) begin
            blank_lz = 1'($urandom_range(0, 1));
            dp_mask  = N'($urandom_range(0, 15));
            do_load(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
            tick(int'($urandom_range(0, 40)));
        end
        tick(100);

        @(negedge board_clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
